// File: rtl/stepper_move_seq.sv
// ---------------------------------------------------------------------------
// stepper_move_seq
//
// Motion sequencer for the lid stepper.  Arbitrates open/close requests,
// tracks the absolute lid position and produces the 8-phase half-step coil
// pattern at a fixed step rate.  After an open move the lid is held for a
// dwell period and then closed automatically.
//
// Parameters
//   STEP_DIV   clk cycles per half-step (>= 2)
//   DWELL      clk cycles the lid is held open before auto-close (>= 1)
//   POS_W      position counter width
//   OPEN_POS   open target position  (< 2**POS_W)
//   CLOSED_POS closed target position (< 2**POS_W)
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   req_open     level request to move to OPEN_POS, held until ack
//   req_close    level request to move to CLOSED_POS, held until ack
//   stop         abort motion or dwell, return to idle
//   ack          one-cycle pulse: request accepted
//   busy         high while moving
//   done         one-cycle pulse: target reached
//   dwell_active high while holding the lid open
//   pos          current absolute position
//   step_drive   coil pattern (0000 when idle)
//
// Every output is a flop, loaded from the next-state decode.
// ---------------------------------------------------------------------------
module stepper_move_seq #(
    parameter int STEP_DIV   = 100000,
    parameter int DWELL      = 268435456,
    parameter int POS_W      = 11,
    parameter int OPEN_POS   = 400,
    parameter int CLOSED_POS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_open,
    input  logic             req_close,
    input  logic             stop,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic             dwell_active,
    output logic [POS_W-1:0] pos,
    output logic [3:0]       step_drive
);

    localparam int STEP_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DWELL_W = $clog2(DWELL + 1);

    localparam logic [POS_W-1:0]   OPEN_P     = POS_W'(OPEN_POS);
    localparam logic [POS_W-1:0]   CLOSED_P   = POS_W'(CLOSED_POS);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [POS_W-1:0]   pos_nxt;
    logic [POS_W-1:0]   target;
    logic [POS_W-1:0]   target_nxt;
    logic [2:0]         phase;
    logic [2:0]         phase_nxt;
    logic [STEP_W-1:0]  step_cnt;
    logic [STEP_W-1:0]  step_cnt_nxt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_cnt_nxt;
    logic               ack_nxt;
    logic               done_nxt;
    logic               step_tick;

    // Half-step coil sequence indexed by the 3-bit phase.
    function automatic logic [3:0] coil_pattern(input logic [2:0] ph);
        logic [3:0] pat;
        case (ph)
            3'd0:    pat = 4'b0001;
            3'd1:    pat = 4'b0011;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b1100;
            3'd6:    pat = 4'b1000;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    assign step_tick = (step_cnt == STEP_LAST);

    // Next-state, position and pulse decode
    always_comb begin
        state_nxt     = state;
        pos_nxt       = pos;
        phase_nxt     = phase;
        target_nxt    = target;
        step_cnt_nxt  = step_cnt;
        dwell_cnt_nxt = dwell_cnt;
        ack_nxt       = 1'b0;
        done_nxt      = 1'b0;

        case (state)
            S_IDLE: begin
                if (!stop) begin
                    if (req_open) begin
                        target_nxt   = OPEN_P;
                        ack_nxt      = 1'b1;
                        step_cnt_nxt = '0;
                        state_nxt    = S_MOVE;
                    end else if (req_close) begin
                        target_nxt   = CLOSED_P;
                        ack_nxt      = 1'b1;
                        step_cnt_nxt = '0;
                        state_nxt    = S_MOVE;
                    end
                end
            end

            S_MOVE: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (pos == target) begin
                    // Arrival cycle.  A stepped move already pulsed done on
                    // the final step; a zero-length move pulses it here.
                    done_nxt = !done;
                    if (target == OPEN_P) begin
                        state_nxt     = S_DWELL;
                        dwell_cnt_nxt = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (step_tick) begin
                    step_cnt_nxt = '0;
                    if (target > pos) begin
                        pos_nxt   = pos + POS_W'(1);
                        phase_nxt = phase + 3'd1;
                    end else begin
                        pos_nxt   = pos - POS_W'(1);
                        phase_nxt = phase - 3'd1;
                    end
                    done_nxt = (pos_nxt == target);
                end else begin
                    step_cnt_nxt = step_cnt + STEP_W'(1);
                end
            end

            S_DWELL: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (req_open) begin
                    // Re-open request just extends the hold.
                    ack_nxt       = 1'b1;
                    dwell_cnt_nxt = '0;
                end else if (req_close) begin
                    ack_nxt      = 1'b1;
                    target_nxt   = CLOSED_P;
                    step_cnt_nxt = '0;
                    state_nxt    = S_MOVE;
                end else if (dwell_cnt == DWELL_LAST) begin
                    // Auto-close: internal move, no ack.
                    target_nxt   = CLOSED_P;
                    step_cnt_nxt = '0;
                    state_nxt    = S_MOVE;
                end else begin
                    dwell_cnt_nxt = dwell_cnt + DWELL_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pos          <= '0;
            phase        <= 3'd0;
            target       <= '0;
            step_cnt     <= '0;
            dwell_cnt    <= '0;
            ack          <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            dwell_active <= 1'b0;
            step_drive   <= 4'b0000;
        end else begin
            state        <= state_nxt;
            pos          <= pos_nxt;
            phase        <= phase_nxt;
            target       <= target_nxt;
            step_cnt     <= step_cnt_nxt;
            dwell_cnt    <= dwell_cnt_nxt;
            ack          <= ack_nxt;
            done         <= done_nxt;
            busy         <= (state_nxt == S_MOVE);
            dwell_active <= (state_nxt == S_DWELL);
            step_drive   <= (state_nxt == S_IDLE) ? 4'b0000 : coil_pattern(phase_nxt);
        end
    end

endmodule

// File: tb/tb_stepper_move_seq.sv
// ---------------------------------------------------------------------------
// tb_stepper_move_seq
//
// Self-checking bench for stepper_move_seq with a small step divider and
// dwell.  A behavioural model keeps absolute event times (next step edge,
// arrival edge, dwell expiry edge) and predicts every output each cycle.
// Directed scenarios are followed by randomized request/stop traffic.
// ---------------------------------------------------------------------------
module tb_stepper_move_seq;

    localparam int STEP_DIV   = 4;
    localparam int DWELL      = 20;
    localparam int POS_W      = 11;
    localparam int OPEN_POS   = 5;
    localparam int CLOSED_POS = 0;

    localparam int MD_IDLE  = 0;
    localparam int MD_MOVE  = 1;
    localparam int MD_DWELL = 2;

    logic             clk;
    logic             rst;
    logic             req_open;
    logic             req_close;
    logic             stop;
    logic             ack;
    logic             busy;
    logic             done;
    logic             dwell_active;
    logic [POS_W-1:0] pos;
    logic [3:0]       step_drive;

    stepper_move_seq #(
        .STEP_DIV   (STEP_DIV),
        .DWELL      (DWELL),
        .POS_W      (POS_W),
        .OPEN_POS   (OPEN_POS),
        .CLOSED_POS (CLOSED_POS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_open     (req_open),
        .req_close    (req_close),
        .stop         (stop),
        .ack          (ack),
        .busy         (busy),
        .done         (done),
        .dwell_active (dwell_active),
        .pos          (pos),
        .step_drive   (step_drive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;

    // Bench-side request/stop state
    bit ro_r, rc_r, st_pulse, rst_r, rnd_mode;
    int ack_q[$];
    int done_q[$];

    // Reference model state (values after the most recent modelled edge)
    int     m_mode, m_pos, m_target, m_ack_kind;
    longint m_t, m_next_step, m_finish, m_dwell_end;
    bit     m_zero, m_ack, m_done;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    function automatic logic [3:0] ref_coil(input int p);
        logic [3:0] tbl [8];
        tbl = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
        return tbl[p % 8];
    endfunction

    task automatic model_reset();
        m_mode = MD_IDLE; m_pos = 0; m_target = 0; m_ack_kind = 0;
        m_next_step = -1; m_finish = -1; m_dwell_end = -1;
        m_zero = 0; m_ack = 0; m_done = 0;
    endtask

    // kind: 1 = open request, 2 = close request, 0 = internal (no ack)
    task automatic start_move(input int tg, input int kind);
        m_ack       = (kind != 0);
        m_ack_kind  = kind;
        m_target    = tg;
        m_mode      = MD_MOVE;
        m_next_step = m_t + STEP_DIV;
        if (m_pos == tg) begin
            m_finish = m_t + 1;
            m_zero   = 1;
        end else begin
            m_finish = -1;
            m_zero   = 0;
        end
    endtask

    task automatic model_step(input bit ro, input bit rc, input bit st, input bit r);
        m_t++;
        m_ack = 0; m_done = 0; m_ack_kind = 0;
        if (r) begin
            model_reset();
            return;
        end
        case (m_mode)
            MD_IDLE: begin
                if (!st) begin
                    if (ro)      start_move(OPEN_POS, 1);
                    else if (rc) start_move(CLOSED_POS, 2);
                end
            end
            MD_MOVE: begin
                if (st) begin
                    m_mode = MD_IDLE;
                end else if (m_t == m_finish) begin
                    m_done = m_zero;
                    if (m_target == OPEN_POS) begin
                        m_mode      = MD_DWELL;
                        m_dwell_end = m_t + DWELL;
                    end else begin
                        m_mode = MD_IDLE;
                    end
                end else if (m_t == m_next_step) begin
                    m_pos       = m_pos + ((m_target > m_pos) ? 1 : -1);
                    m_next_step = m_next_step + STEP_DIV;
                    if (m_pos == m_target) begin
                        m_done   = 1;
                        m_finish = m_t + 1;
                        m_zero   = 0;
                    end
                end
            end
            default: begin
                if (st) begin
                    m_mode = MD_IDLE;
                end else if (ro) begin
                    m_ack = 1; m_ack_kind = 1;
                    m_dwell_end = m_t + DWELL;
                end else if (rc) begin
                    start_move(CLOSED_POS, 2);
                end else if (m_t == m_dwell_end) begin
                    start_move(CLOSED_POS, 0);
                end
            end
        endcase
    endtask

    // One clock: check outputs of the last edge, then drive inputs for the next.
    task automatic tick();
        bit st_now;
        @(negedge clk);
        ncyc++;
        check_val("ack",          ack,          m_ack);
        check_val("done",         done,         m_done);
        check_val("busy",         busy,         m_mode == MD_MOVE);
        check_val("dwell_active", dwell_active, m_mode == MD_DWELL);
        check_val("pos",          pos,          m_pos);
        check_val("step_drive",   step_drive,   (m_mode == MD_IDLE) ? 4'b0000 : ref_coil(m_pos));
        if (ack)  ack_q.push_back(ncyc);
        if (done) done_q.push_back(ncyc);
        if (m_ack_kind == 1 && (!rnd_mode || $urandom_range(3) != 0)) ro_r = 0;
        if (m_ack_kind == 2 && (!rnd_mode || $urandom_range(3) != 0)) rc_r = 0;
        st_now = st_pulse;
        if (rnd_mode) begin
            if (!ro_r && $urandom_range(40) == 0) ro_r = 1;
            if (!rc_r && $urandom_range(40) == 0) rc_r = 1;
            if ($urandom_range(100) == 0) st_now = 1;
        end
        st_pulse  = 0;
        req_open  = ro_r;
        req_close = rc_r;
        stop      = st_now;
        rst       = rst_r;
        model_step(ro_r, rc_r, st_now, rst_r);
    endtask

    initial begin
        rst = 1'b1; req_open = 1'b0; req_close = 1'b0; stop = 1'b0;
        ro_r = 0; rc_r = 0; st_pulse = 0; rst_r = 1; rnd_mode = 0;
        m_t = 0;
        model_reset();

        // Reset state
        repeat (3) tick();
        rst_r = 0;
        repeat (5) tick();

        // Full open / dwell / auto-close cycle
        ack_q.delete(); done_q.delete();
        ro_r = 1;
        repeat (80) tick();
        check_val("s1_ack_count",  ack_q.size(),  1);
        check_val("s1_done_count", done_q.size(), 2);
        if (ack_q.size() == 1 && done_q.size() == 2) begin
            check_val("s1_open_latency",  done_q[0] - ack_q[0], 20);
            check_val("s1_close_latency", done_q[1] - ack_q[0], 61);
        end
        check_val("s1_end_pos",   pos,        0);
        check_val("s1_end_drive", step_drive, 4'b0000);

        // req_close during dwell closes immediately
        ro_r = 1;
        for (int i = 0; i < 40 && !dwell_active; i++) tick();
        check_val("s2_in_dwell", dwell_active, 1);
        repeat (3) tick();
        rc_r = 1;
        repeat (30) tick();
        check_val("s2_end_pos", pos, 0);

        // Simultaneous open and close in idle: open first
        ack_q.delete();
        ro_r = 1; rc_r = 1;
        repeat (60) tick();
        check_val("s3_two_acks", ack_q.size(), 2);
        check_val("s3_end_pos",  pos, 0);

        // Stop mid-open at pos 3, then close from there
        ro_r = 1;
        for (int i = 0; i < 40 && pos != 3; i++) tick();
        check_val("s4_reach3", pos, 3);
        st_pulse = 1;
        done_q.delete();
        repeat (40) tick();
        check_val("s4_hold_pos",   pos, 3);
        check_val("s4_hold_drive", step_drive, 4'b0000);
        check_val("s4_no_done",    done_q.size(), 0);
        rc_r = 1;
        repeat (25) tick();
        check_val("s4_close_pos", pos, 0);

        // Close request while already closed
        done_q.delete();
        rc_r = 1;
        repeat (6) tick();
        check_val("s5_zero_done", done_q.size(), 1);

        // Asynchronous reset mid-move at pos 2
        ro_r = 1;
        for (int i = 0; i < 40 && pos != 2; i++) tick();
        check_val("s6_reach2", pos, 2);
        ro_r = 0;
        #2;
        rst = 1'b1; rst_r = 1;
        #1;
        check_val("s6_async_pos",   pos, 0);
        check_val("s6_async_busy",  busy, 0);
        check_val("s6_async_drive", step_drive, 4'b0000);
        check_val("s6_async_ack",   ack, 0);
        check_val("s6_async_done",  done, 0);
        model_reset();
        repeat (3) tick();
        rst_r = 0;
        ack_q.delete(); done_q.delete();
        repeat (10) tick();
        check_val("s6_no_pulses", ack_q.size() + done_q.size(), 0);

        // Randomized traffic
        rnd_mode = 1;
        repeat (3000) tick();
        rnd_mode = 0;
        ro_r = 0; rc_r = 0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
